fir_ctrl: RTL and testbench
===========================

# fir_ctrl

Sequencing and configuration controller for the FIR tap chain. It loads a new coefficient set through a valid/ready stream into a shadow bank and commits it atomically to the active bank. It then flushes the delay line with zero samples and gates the input sample stream into the filter. It sits between the sample/config sources and the `fir_filter` instance, driving its `coeffs` and `signal` inputs.

## Interface
- `N_TAPS`, 8, number of taps; coefficient bank depth
- `COEFF_W`, 3, coefficient width
- `SAMPLE_W`, 3, sample width
- Clock and reset: one clock; reset is synchronous and active-high.
- `i_clk`  in  1  rising-edge clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_cfg_valid`  in  1  coefficient beat valid
- `o_cfg_ready`  out  1  coefficient beat accepted when valid&ready
- `i_cfg_data`  in  COEFF_W  coefficient; beats ordered tap 0 first
- `i_cfg_last`  in  1  final beat of the set
- `i_reload`  in  1  pulse in RUN: abandon RUN, start a new load
- `i_sample`  in  SAMPLE_W  input sample
- `i_sample_valid`  in  1  sample valid
- `o_sample_ready`  out  1  sample accepted when valid&ready
- `o_sample`  out  SAMPLE_W  registered sample to the filter `signal` input
- `o_coeffs`  out  N_TAPS*COEFF_W  active bank, flat; tap k at bits [k*COEFF_W +: COEFF_W]
- `o_running`  out  1  high in RUN

## Operation
- States: LOAD, COMMIT, FLUSH, RUN. Reset enters LOAD.
- Reset values:
  - shadow and active banks all 0, so `o_coeffs`=0
  - write index 0, flush counter 0
  - `o_sample`=0, `o_cfg_ready`=0, `o_sample_ready`=0, `o_running`=0
  - `o_cfg_ready` rises one cycle after reset deasserts.
- LOAD:
  - `o_cfg_ready`=1, `o_sample`=0.
  - Each accepted beat writes shadow[idx], then idx increments.
  - The beat with `i_cfg_last`=1, or the beat at idx=N_TAPS-1 (implicit last), moves to COMMIT.
  - `i_cfg_last` on the implicit-last beat is redundant and causes no error.
- COMMIT (1 cycle):
  - `o_cfg_ready`=0.
  - active <= shadow, with entries at indices >= the beat count zero-filled.
  - Shadow and idx clear. Go to FLUSH.
- FLUSH:
  - `o_sample`=0 for exactly N_TAPS cycles, counted by the flush counter, then go to RUN.
  - `o_cfg_ready`=0, `o_sample_ready`=0.
- RUN:
  - `o_sample_ready`=1, `o_running`=1.
  - `o_sample` <= `i_sample_valid` ? `i_sample` : 0. A zero is inserted whenever no sample is valid, because the filter clocks every cycle.
  - `i_cfg_valid` is ignored (ready=0).
  - `i_reload`=1 goes to LOAD. A sample valid in the same cycle is still accepted and registered.
  - The active bank holds its values through LOAD until the next COMMIT.
- `i_reload` outside RUN is ignored.
- `i_rst` in any state, including mid-load or mid-flush:
  - the partial shadow is discarded, active is zeroed, and the state returns to LOAD.

## Timing
- Config: last beat accepted at edge t.
  - State is COMMIT in cycle t+1.
  - `o_coeffs` carries the new set from cycle t+2.
  - FLUSH spans cycles t+2 .. t+1+N_TAPS.
  - RUN starts, with `o_sample_ready` high, at cycle t+2+N_TAPS.
- Sample path: one-cycle latency. A sample accepted at edge t appears on `o_sample` in cycle t+1.
- Reload: `i_reload` sampled at edge t.
  - `o_sample_ready`=0 and `o_cfg_ready`=1 from cycle t+1.
  - `o_sample`=0 from cycle t+2.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum config-to-run turnaround: beats + 1 + N_TAPS cycles.

## Structure
- Shared package `fir_pkg`:
  - default N_TAPS, COEFF_W, SAMPLE_W
  - state enum (LOAD, COMMIT, FLUSH, RUN)
  - the index and flush counter width, $clog2(N_TAPS+1)
- One natural sub-module, `fir_coeff_bank`:
  - shadow/active register pair
  - write port, commit strobe with zero-fill above the beat count, flat output
- The FSM, counters and sample register stay in `fir_ctrl`.

## Test plan
- Reset, then 8 beats 0..7 without `i_cfg_last`: implicit last at beat 8. `o_coeffs` tap k = k two cycles later; `o_sample`=0 for 8 cycles; `o_running`=1 at cycle 10 after the last beat.
- 3 beats 5,6,7 with last on the third: taps 0..2 = 5,6,7 and taps 3..7 = 0; FLUSH lasts exactly 8 cycles.
- RUN, sample 3 valid for one cycle then invalid: `o_sample`=3 for one cycle, then 0; `o_sample_ready` stays 1.
- RUN, `i_reload` with `i_sample_valid`=1 and sample 6 in the same cycle:
  - `o_sample`=6 next cycle, then 0
  - `o_cfg_ready`=1 and old coefficients held until the next COMMIT
- `i_rst` after 4 of 8 beats: `o_coeffs`=0 and state LOAD. A subsequent full load of all-7 commits with no remnants of the partial set.
- `i_cfg_valid` held high during FLUSH and RUN: no beats accepted (`o_cfg_ready`=0) and `o_coeffs` unchanged.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared defaults, FSM state encoding and counter sizing for the FIR
// controller and its coefficient bank.
package fir_pkg;

    localparam int DEF_N_TAPS   = 8;
    localparam int DEF_COEFF_W  = 3;
    localparam int DEF_SAMPLE_W = 3;

    // Write index and flush counter must be able to hold the value N_TAPS.
    function automatic int cnt_width(input int n_taps);
        return $clog2(n_taps + 1);
    endfunction

    localparam int DEF_CNT_W = $clog2(DEF_N_TAPS + 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMMIT,
        ST_FLUSH,
        ST_RUN
    } state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register pair: beats land in the shadow bank,
// a commit strobe copies it to the active bank with zero-fill above the count.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int N_TAPS  = DEF_N_TAPS,
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_wr_en,
    input  logic [CNT_W-1:0]            i_wr_idx,
    input  logic [COEFF_W-1:0]          i_wr_data,
    input  logic                        i_commit,
    input  logic [CNT_W-1:0]            i_count,
    output logic [N_TAPS*COEFF_W-1:0]   o_coeffs
);

    logic [COEFF_W-1:0] shadow_q [N_TAPS];
    logic [COEFF_W-1:0] shadow_d [N_TAPS];
    logic [COEFF_W-1:0] active_q [N_TAPS];
    logic [COEFF_W-1:0] active_d [N_TAPS];

    // NOTE: every element gets its hold value before any condition, so no
    // path through this block leaves a variable unassigned (no latch).
    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            shadow_d[k] = shadow_q[k];
            active_d[k] = active_q[k];
            if (i_commit) begin
                active_d[k] = (CNT_W'(k) < i_count) ? shadow_q[k] : '0;
                shadow_d[k] = '0;
            end else if (i_wr_en && (i_wr_idx == CNT_W'(k))) begin
                shadow_d[k] = i_wr_data;
            end
        end
    end

    // NOTE: both banks are reset explicitly; a partial set must never leak
    // into a later commit, and the filter must see zero taps after reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_TAPS; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
        end
    end

    always_comb begin
        o_coeffs = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            o_coeffs[k*COEFF_W +: COEFF_W] = active_q[k];
        end
    end

endmodule

// File: rtl/fir_ctrl.sv
// FIR sequencing controller: loads a coefficient set, commits it, flushes the
// delay line with zeros, then gates the sample stream into the filter.
module fir_ctrl
    import fir_pkg::*;
#(
    parameter int N_TAPS   = DEF_N_TAPS,
    parameter int COEFF_W  = DEF_COEFF_W,
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cfg_valid,
    output logic                        o_cfg_ready,
    input  logic [COEFF_W-1:0]          i_cfg_data,
    input  logic                        i_cfg_last,
    input  logic                        i_reload,
    input  logic [SAMPLE_W-1:0]         i_sample,
    input  logic                        i_sample_valid,
    output logic                        o_sample_ready,
    output logic [SAMPLE_W-1:0]         o_sample,
    output logic [N_TAPS*COEFF_W-1:0]   o_coeffs,
    output logic                        o_running
);

    localparam int                CNT_W    = cnt_width(N_TAPS);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_TAPS - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     flush_q, flush_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic                 sample_ready_q, sample_ready_d;
    logic                 running_q, running_d;
    logic [SAMPLE_W-1:0]  sample_q, sample_d;

    logic                 cfg_fire;
    logic                 sample_fire;
    logic                 last_beat;
    logic                 commit;

    // Handshakes use the registered ready, so acceptance never depends
    // combinationally on the ready we are presenting.
    assign cfg_fire    = i_cfg_valid && cfg_ready_q && (state_q == ST_LOAD);
    assign sample_fire = i_sample_valid && sample_ready_q && (state_q == ST_RUN);
    assign last_beat   = cfg_fire && (i_cfg_last || (idx_q == LAST_IDX));
    assign commit      = (state_q == ST_COMMIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:   if (last_beat) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_FLUSH;
            ST_FLUSH:  if (flush_q == LAST_IDX) state_d = ST_RUN;
            ST_RUN:    if (i_reload) state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
    end

    // Registered outputs are derived from the next state so they line up
    // with the state they describe.
    always_comb begin
        cfg_ready_d    = (state_d == ST_LOAD);
        sample_ready_d = (state_d == ST_RUN);
        running_d      = (state_d == ST_RUN);
        sample_d       = sample_fire ? i_sample : '0;
    end

    always_comb begin
        idx_d = idx_q;
        if (commit) begin
            idx_d = '0;
        end else if (cfg_fire) begin
            idx_d = idx_q + CNT_W'(1);
        end
        flush_d = (state_q == ST_FLUSH) ? flush_q + CNT_W'(1) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx_q          <= '0;
            flush_q        <= '0;
            cfg_ready_q    <= 1'b0;
            sample_ready_q <= 1'b0;
            running_q      <= 1'b0;
            sample_q       <= '0;
        end else begin
            idx_q          <= idx_d;
            flush_q        <= flush_d;
            cfg_ready_q    <= cfg_ready_d;
            sample_ready_q <= sample_ready_d;
            running_q      <= running_d;
            sample_q       <= sample_d;
        end
    end

    fir_coeff_bank #(
        .N_TAPS  (N_TAPS),
        .COEFF_W (COEFF_W),
        .CNT_W   (CNT_W)
    ) u_bank (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (cfg_fire),
        .i_wr_idx  (idx_q),
        .i_wr_data (i_cfg_data),
        .i_commit  (commit),
        .i_count   (idx_q),
        .o_coeffs  (o_coeffs)
    );

    assign o_cfg_ready    = cfg_ready_q;
    assign o_sample_ready = sample_ready_q;
    assign o_running      = running_q;
    assign o_sample       = sample_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Scenario bench for fir_ctrl: coefficient load/commit/flush timing, sample
// gating through a scoreboard queue, reload and mid-load reset behaviour.
module tb_fir_ctrl;

    localparam int N_TAPS   = 8;
    localparam int COEFF_W  = 3;
    localparam int SAMPLE_W = 3;

    logic                       i_clk = 1'b0;
    logic                       i_rst;
    logic                       i_cfg_valid;
    logic                       o_cfg_ready;
    logic [COEFF_W-1:0]         i_cfg_data;
    logic                       i_cfg_last;
    logic                       i_reload;
    logic [SAMPLE_W-1:0]        i_sample;
    logic                       i_sample_valid;
    logic                       o_sample_ready;
    logic [SAMPLE_W-1:0]        o_sample;
    logic [N_TAPS*COEFF_W-1:0]  o_coeffs;
    logic                       o_running;

    always #5 i_clk = ~i_clk;

    fir_ctrl #(
        .N_TAPS   (N_TAPS),
        .COEFF_W  (COEFF_W),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cfg_valid    (i_cfg_valid),
        .o_cfg_ready    (o_cfg_ready),
        .i_cfg_data     (i_cfg_data),
        .i_cfg_last     (i_cfg_last),
        .i_reload       (i_reload),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .o_sample       (o_sample),
        .o_coeffs       (o_coeffs),
        .o_running      (o_running)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [COEFF_W-1:0]         cfg_vals [N_TAPS];
    logic [N_TAPS*COEFF_W-1:0]  exp_coeffs = '0;
    logic [SAMPLE_W-1:0]        sample_sb [$];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({o_cfg_ready, o_sample_ready, o_running, o_sample} !== 6'b0) begin
            $display("FAIL reset_outputs: got rdy/srdy/run/sample=%b required 000000",
                     {o_cfg_ready, o_sample_ready, o_running, o_sample});
        end else n_pass++;
        n_checks++;
        if (o_coeffs !== '0) begin
            $display("FAIL reset_coeffs: got %h required 0", o_coeffs);
        end else n_pass++;
        i_rst = 1'b0;
        tick();
        n_checks++;
        if (o_cfg_ready !== 1'b1) begin
            $display("FAIL reset_cfg_ready_rise: got %b required 1", o_cfg_ready);
        end else n_pass++;
        exp_coeffs = '0;
    endtask

    // Sends n beats from cfg_vals, then checks commit, flush length and RUN entry.
    task automatic load_cfg(input int n, input bit with_last, input bit hold_valid);
        logic [N_TAPS*COEFF_W-1:0] old_coeffs;
        logic [N_TAPS*COEFF_W-1:0] new_coeffs;
        int waited;
        old_coeffs = exp_coeffs;
        new_coeffs = '0;
        for (int k = 0; k < n; k++) new_coeffs[k*COEFF_W +: COEFF_W] = cfg_vals[k];
        waited = 0;
        while (o_cfg_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (o_cfg_ready !== 1'b1) begin
            $display("FAIL load_wait_ready: got %b required 1 within 20 cycles", o_cfg_ready);
        end else n_pass++;

        for (int i = 0; i < n; i++) begin
            i_cfg_valid = 1'b1;
            i_cfg_data  = cfg_vals[i];
            i_cfg_last  = with_last && (i == n - 1);
            tick();
            if (i < n - 1) begin
                n_checks++;
                if ({o_cfg_ready, o_sample} !== {1'b1, {SAMPLE_W{1'b0}}}) begin
                    $display("FAIL load_beat%0d: got rdy/sample=%b required 1000", i,
                             {o_cfg_ready, o_sample});
                end else n_pass++;
            end
        end
        i_cfg_valid = hold_valid;
        i_cfg_last  = 1'b0;
        i_cfg_data  = 3'd1;

        n_checks++;
        if (o_cfg_ready !== 1'b0 || o_coeffs !== old_coeffs) begin
            $display("FAIL commit_cycle: got rdy=%b coeffs=%h required rdy=0 coeffs=%h",
                     o_cfg_ready, o_coeffs, old_coeffs);
        end else n_pass++;
        tick();
        n_checks++;
        if (o_coeffs !== new_coeffs) begin
            $display("FAIL new_coeffs: got %h required %h", o_coeffs, new_coeffs);
        end else n_pass++;
        exp_coeffs = new_coeffs;

        for (int c = 0; c < N_TAPS; c++) begin
            n_checks++;
            if ({o_cfg_ready, o_sample_ready, o_running, o_sample} !== 6'b0 ||
                o_coeffs !== exp_coeffs) begin
                $display("FAIL flush_cycle%0d: got rdy/srdy/run/sample=%b coeffs=%h required 000000 coeffs=%h",
                         c, {o_cfg_ready, o_sample_ready, o_running, o_sample}, o_coeffs, exp_coeffs);
            end else n_pass++;
            tick();
        end
        n_checks++;
        if ({o_cfg_ready, o_sample_ready, o_running} !== 3'b011) begin
            $display("FAIL run_entry: got rdy/srdy/run=%b required 011",
                     {o_cfg_ready, o_sample_ready, o_running});
        end else n_pass++;
    endtask

    // Random sample stream through the scoreboard while in RUN.
    task automatic run_samples(input int cycles, input bit hold_cfg);
        logic [SAMPLE_W-1:0] got_exp;
        i_cfg_valid = hold_cfg;
        for (int c = 0; c < cycles; c++) begin
            i_sample_valid = 1'($urandom_range(0, 1));
            i_sample       = SAMPLE_W'($urandom);
            sample_sb.push_back(i_sample_valid ? i_sample : '0);
            tick();
            got_exp = (sample_sb.size() > 0) ? sample_sb.pop_front() : 'x;
            n_checks++;
            if (o_sample !== got_exp || o_sample_ready !== 1'b1 || o_cfg_ready !== 1'b0) begin
                $display("FAIL run_sample%0d: got sample=%0d srdy=%b rdy=%b required sample=%0d srdy=1 rdy=0",
                         c, o_sample, o_sample_ready, o_cfg_ready, got_exp);
            end else n_pass++;
        end
        i_sample_valid = 1'b0;
        i_cfg_valid    = 1'b0;
        n_checks++;
        if (o_coeffs !== exp_coeffs) begin
            $display("FAIL run_coeffs_stable: got %h required %h", o_coeffs, exp_coeffs);
        end else n_pass++;
    endtask

    task automatic test_implicit_last();
        for (int k = 0; k < N_TAPS; k++) cfg_vals[k] = COEFF_W'(k);
        load_cfg(N_TAPS, 1'b0, 1'b0);
    endtask

    task automatic test_single_sample();
        logic [SAMPLE_W-1:0] e;
        i_sample_valid = 1'b1;
        i_sample       = 3'd3;
        sample_sb.push_back(3'd3);
        tick();
        i_sample_valid = 1'b0;
        i_sample       = 3'd5;
        sample_sb.push_back(3'd0);
        e = sample_sb.pop_front();
        n_checks++;
        if (o_sample !== e || o_sample_ready !== 1'b1) begin
            $display("FAIL single_sample: got sample=%0d srdy=%b required sample=%0d srdy=1",
                     o_sample, o_sample_ready, e);
        end else n_pass++;
        tick();
        e = sample_sb.pop_front();
        n_checks++;
        if (o_sample !== e || o_sample_ready !== 1'b1) begin
            $display("FAIL single_sample_zero: got sample=%0d srdy=%b required sample=%0d srdy=1",
                     o_sample, o_sample_ready, e);
        end else n_pass++;
        run_samples(12, 1'b0);
    endtask

    task automatic test_reload();
        logic [SAMPLE_W-1:0] e;
        i_reload       = 1'b1;
        i_sample_valid = 1'b1;
        i_sample       = 3'd6;
        sample_sb.push_back(3'd6);
        tick();
        i_reload = 1'b0;
        i_sample = 3'd5;
        sample_sb.push_back(3'd0);
        e = sample_sb.pop_front();
        n_checks++;
        if (o_sample !== e || {o_cfg_ready, o_sample_ready, o_running} !== 3'b100) begin
            $display("FAIL reload_edge: got sample=%0d rdy/srdy/run=%b required sample=%0d 100",
                     o_sample, {o_cfg_ready, o_sample_ready, o_running}, e);
        end else n_pass++;
        tick();
        i_sample_valid = 1'b0;
        i_reload       = 1'b1;
        e = sample_sb.pop_front();
        n_checks++;
        if (o_sample !== e) begin
            $display("FAIL reload_zero: got sample=%0d required %0d", o_sample, e);
        end else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (o_coeffs !== exp_coeffs || o_cfg_ready !== 1'b1 || o_running !== 1'b0) begin
                $display("FAIL load_hold%0d: got coeffs=%h rdy=%b run=%b required coeffs=%h rdy=1 run=0",
                         c, o_coeffs, o_cfg_ready, o_running, exp_coeffs);
            end else n_pass++;
        end
        i_reload = 1'b0;
    endtask

    task automatic test_short_load();
        cfg_vals[0] = 3'd5;
        cfg_vals[1] = 3'd6;
        cfg_vals[2] = 3'd7;
        load_cfg(3, 1'b1, 1'b1);
        run_samples(8, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        i_reload = 1'b1;
        tick();
        i_reload = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            i_cfg_valid = 1'b1;
            i_cfg_data  = COEFF_W'(i + 1);
            i_cfg_last  = 1'b0;
            tick();
        end
        i_cfg_valid = 1'b0;
        i_rst       = 1'b1;
        tick();
        i_rst = 1'b0;
        n_checks++;
        if (o_coeffs !== '0 || {o_cfg_ready, o_sample_ready, o_running, o_sample} !== 6'b0) begin
            $display("FAIL mid_load_reset: got coeffs=%h rdy/srdy/run/sample=%b required 0 000000",
                     o_coeffs, {o_cfg_ready, o_sample_ready, o_running, o_sample});
        end else n_pass++;
        exp_coeffs = '0;
        for (int k = 0; k < N_TAPS; k++) cfg_vals[k] = 3'd7;
        load_cfg(2, 1'b1, 1'b0);
        i_reload = 1'b1;
        tick();
        i_reload = 1'b0;
        load_cfg(N_TAPS, 1'b1, 1'b0);
        run_samples(6, 1'b0);
    endtask

    initial begin
        i_rst          = 1'b1;
        i_cfg_valid    = 1'b0;
        i_cfg_data     = '0;
        i_cfg_last     = 1'b0;
        i_reload       = 1'b0;
        i_sample       = '0;
        i_sample_valid = 1'b0;

        test_reset();
        test_implicit_last();
        test_single_sample();
        test_reload();
        test_short_load();
        test_reset_mid_load();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
